// File: rtl/adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encoding and counter sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // One extra bit so a power-of-two WIDTH never wraps to zero.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_fa.sv
// One-bit full-adder cell used as the serial add slice.
// Purely combinational.
module FA (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic S,
    output logic Cout
);

    assign S    = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one FA cell plus a carry flop,
// LSB first, start/busy/done handshake.
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = cnt_width(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] acc_sr_q, acc_sr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fa_s;
    logic             fa_cout;

    FA u_fa (
        .A    (a_sr_q[0]),
        .B    (b_sr_q[0]),
        .Cin  (carry_q),
        .S    (fa_s),
        .Cout (fa_cout)
    );

    // Next-state, datapath shifts and registered handshake outputs.
    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        acc_sr_d = acc_sr_q;
        count_d  = count_q;
        carry_d  = carry_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            SHIFT: begin
                acc_sr_d = {fa_s, acc_sr_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                carry_d  = fa_cout;
                count_d  = count_q + CW'(1);
                if (count_q == CW'(WIDTH - 1)) begin
                    sum_d   = {fa_s, acc_sr_q[WIDTH-1:1]};
                    cout_d  = fa_cout;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            // IDLE, and the unused code 11 which behaves as IDLE.
            default: begin
                state_d = IDLE;
                if (start) begin
                    a_sr_d   = a;
                    b_sr_d   = b;
                    carry_d  = cin;
                    count_d  = '0;
                    acc_sr_d = '0;
                    state_d  = SHIFT;
                end
            end
        endcase
        busy_d = (state_d == SHIFT) || (state_d == DONE);
        done_d = (state_d == DONE);
    end

    // All state updates with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            acc_sr_q <= '0;
            count_q  <= '0;
            carry_q  <= 1'b0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            acc_sr_q <= acc_sr_d;
            count_q  <= count_d;
            carry_q  <= carry_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder at WIDTH=8 and WIDTH=5.
// Timeline model plus directed literal checks.
module tb_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       s8, c8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       s5, c5, busy5, done5, cout5;
    logic [4:0] a5, b5, sum5;

    int checks = 0;
    int errors = 0;
    bit armed  = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8), .cin(c8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder #(.WIDTH(5)) u5 (
        .clk(clk), .rst_n(rst_n), .start(s5), .a(a5), .b(b5), .cin(c5),
        .busy(busy5), .done(done5), .sum(sum5), .cout(cout5)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Model: an accepted start occupies WIDTH+1 busy cycles,
    // the last of which is the done cycle carrying a+b+cin.
    int         m8_cnt, m5_cnt;
    logic [8:0] m8_res;
    logic [5:0] m5_res;
    logic [7:0] m8_sum;
    logic [4:0] m5_sum;
    logic       m8_cout, m5_cout;

    always @(posedge clk) begin
        if (!rst_n) begin
            m8_cnt = 0; m8_sum = '0; m8_cout = 1'b0;
            m5_cnt = 0; m5_sum = '0; m5_cout = 1'b0;
            armed  = 1;
        end else begin
            if (m8_cnt == 0) begin
                if (s8) begin
                    m8_res = 9'(a8) + 9'(b8) + 9'(c8);
                    m8_cnt = 9;
                end
            end else begin
                m8_cnt--;
                if (m8_cnt == 1) {m8_cout, m8_sum} = m8_res;
            end
            if (m5_cnt == 0) begin
                if (s5) begin
                    m5_res = 6'(a5) + 6'(b5) + 6'(c5);
                    m5_cnt = 6;
                end
            end else begin
                m5_cnt--;
                if (m5_cnt == 1) {m5_cout, m5_sum} = m5_res;
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (armed) begin
            chk("busy8", busy8, m8_cnt != 0);
            chk("done8", done8, m8_cnt == 1);
            chk("sum8", sum8, m8_sum);
            chk("cout8", cout8, m8_cout);
            chk("busy5", busy5, m5_cnt != 0);
            chk("done5", done5, m5_cnt == 1);
            chk("sum5", sum5, m5_sum);
            chk("cout5", cout5, m5_cout);
        end
    end

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done8) chk("done8_timeout", 0, 1);
    endtask

    task automatic wait_done5(output int n);
        n = 0;
        while (!done5 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done5) chk("done5_timeout", 0, 1);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] es,
                       input logic ec, input string nm);
        int n;
        @(negedge clk);
        a8 = a; b8 = b; c8 = c; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
        wait_done8(n);
        chk({nm, "_lat"}, n, 8);
        chk({nm, "_sum"}, sum8, es);
        chk({nm, "_cout"}, cout8, ec);
    endtask

    task automatic op5(input logic [4:0] a, input logic [4:0] b,
                       input logic c, input logic [4:0] es,
                       input logic ec, input string nm);
        int n;
        @(negedge clk);
        a5 = a; b5 = b; c5 = c; s5 = 1'b1;
        @(negedge clk);
        s5 = 1'b0;
        a5 = 5'($urandom); b5 = 5'($urandom); c5 = 1'($urandom);
        wait_done5(n);
        chk({nm, "_lat"}, n, 5);
        chk({nm, "_sum"}, sum5, es);
        chk({nm, "_cout"}, cout5, ec);
    endtask

    task automatic rand8();
        logic [7:0] a, b;
        logic       c;
        logic [8:0] r;
        repeat (1000) begin
            a = 8'($urandom); b = 8'($urandom); c = 1'($urandom);
            r = 9'(a) + 9'(b) + 9'(c);
            op8(a, b, c, r[7:0], r[8], "rand8");
        end
    endtask

    task automatic rand5();
        logic [4:0] a, b;
        logic       c;
        logic [5:0] r;
        repeat (1000) begin
            a = 5'($urandom); b = 5'($urandom); c = 1'($urandom);
            r = 6'(a) + 6'(b) + 6'(c);
            op5(a, b, c, r[4:0], r[5], "rand5");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  seen;
        rst_n = 1'b0;
        s8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0;
        s5 = 1'b0; a5 = '0; b5 = '0; c5 = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_sum", sum8, 0);
        chk("rst_cout", cout8, 0);
        rst_n = 1'b1;

        op8(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, "t1");
        op8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "t2a");
        op8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "t2b");
        op5(5'h1F, 5'h01, 1'b1, 5'h01, 1'b1, "t2c");

        // Second start during SHIFT must be dropped.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; c8 = 1'b0; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (2) @(negedge clk);
        a8 = 8'hAA; b8 = 8'h55; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        wait_done8(n);
        chk("t3_sum", sum8, 8'h30);
        chk("t3_cout", cout8, 0);
        repeat (3) @(negedge clk);
        chk("t3_hold", sum8, 8'h30);
        chk("t3_idle", busy8, 0);

        // Held start: one result every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h01; c8 = 1'b0; s8 = 1'b1;
        wait_done8(n);
        chk("t4_sum0", sum8, 8'h02);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            wait_done8(n);
            chk("t4_period", n + 1, 10);
            chk("t4_sum", sum8, 8'h02);
        end
        s8 = 1'b0;
        repeat (12) @(negedge clk);

        // Reset in the fourth SHIFT cycle aborts the operation.
        a8 = 8'h33; b8 = 8'h44; s8 = 1'b1;
        @(negedge clk);
        s8 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_busy", busy8, 0);
        chk("t5_done", done8, 0);
        chk("t5_sum", sum8, 0);
        chk("t5_cout", cout8, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) seen = 1;
        end
        chk("t5_nodone", seen, 0);

        fork
            rand8();
            rand5();
        join

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
